abs_max_tracker: RTL

- Downstream consumer of the magnitude stage. Takes a stream of signed two's-complement N-bit samples, forms each sample's magnitude (conditional invert plus add-sign), and tracks the largest magnitude, its index and its original sign over a frame of FRAME samples.
- Reports the frame result through a valid/ready output handshake.
- Used in front of the selection and decision logic that needs the dominant element of a vector.

---
 rtl/abs_max_tracker.sv | 130 +++++++++++++
 1 files changed

// File: rtl/abs_max_tracker.sv
// ---------------------------------------------------------------------------
// abs_max_tracker
//
// Takes a frame of FRAME signed two's-complement samples and reports the
// sample with the largest magnitude: its magnitude, its 0-based position in
// the frame and its original sign bit. The result is presented through a
// valid/ready handshake and stays stable until the downstream consumes it.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      begins a new frame (honoured only when idle)
//   in_valid   sample on in_data is valid
//   in_ready   block accepts a sample this cycle (high while running)
//   in_data    signed N-bit sample
//   out_valid  frame result available
//   out_ready  downstream consumes the result
//   max_mag    largest magnitude in the frame (unsigned N bits)
//   max_idx    position of the winning sample
//   max_neg    sign bit of the winning sample
//   busy       high while the frame is being collected
// ---------------------------------------------------------------------------
module abs_max_tracker #(
    parameter int N     = 5,
    parameter int FRAME = 4,
    parameter int IDXW  = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N-1:0]    in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N-1:0]    max_mag,
    output logic [IDXW-1:0] max_idx,
    output logic            max_neg,
    output logic            busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [IDXW:0] LAST = (IDXW + 1)'(FRAME - 1);
    localparam logic [IDXW:0] ONE  = (IDXW + 1)'(1);

    state_t          state;
    state_t          state_nxt;
    logic [IDXW:0]   cnt;
    logic [N-1:0]    mag;
    logic            accept;

    // Conditional invert plus add-sign. The most-negative input wraps to
    // 2^(N-1), which is still representable as an unsigned N-bit value.
    function automatic logic [N-1:0] abs_mag(input logic signed [N-1:0] x);
        logic [N-1:0] inv;
        inv = x ^ {N{x[N-1]}};
        return inv + {{(N-1){1'b0}}, x[N-1]};
    endfunction

    assign mag    = abs_mag(in_data);
    assign accept = (state == RUN) && in_valid;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN:  if (accept && (cnt == LAST)) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            RUN: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // Running maximum and sample counter. The result registers hold their
    // value through IDLE so a late reader still sees the last frame; only a
    // new start clears them. The first sample always loads, and the strict
    // compare lets the earliest index win a tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            max_mag <= '0;
            max_idx <= '0;
            max_neg <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                cnt     <= '0;
                max_mag <= '0;
                max_idx <= '0;
                max_neg <= 1'b0;
            end else if (accept) begin
                if ((cnt == '0) || (mag > max_mag)) begin
                    max_mag <= mag;
                    max_idx <= cnt[IDXW-1:0];
                    max_neg <= in_data[N-1];
                end
                cnt <= cnt + ONE;
            end
        end
    end

endmodule
